// File: rtl/player_move_ctrl.sv
// Tile-locked player movement: keycode -> facing, moving flag and world scroll offset,
// advanced once per VS frame tick. Optional run modifier (B key) under `PLAYER_RUN_EN.
module player_move_ctrl #(
    parameter int unsigned TILE_PX     = 16,
    parameter int unsigned STEP_PX     = 1,
    parameter int unsigned TURN_FRAMES = 4,
    parameter logic [9:0]  X_MAX       = 10'd480,
    parameter logic [9:0]  Y_MAX       = 10'd480,
    parameter logic [9:0]  X_INIT      = 10'd160,
    parameter logic [9:0]  Y_INIT      = 10'd160
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VS,
    input  logic [7:0] Keycode,
    output logic       Character_Moving,
    output logic [1:0] Direction,
    output logic [9:0] Map_X,
    output logic [9:0] Map_Y,
    output logic       Frame_Tick
);
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_TURN    = 2'd1;
    localparam logic [1:0]  S_WALK    = 2'd2;
    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_RIGHT = 2'd1;
    localparam logic [1:0]  DIR_DOWN  = 2'd2;
    localparam logic [1:0]  DIR_LEFT  = 2'd3;
    localparam logic [9:0]  TILE10    = 10'(TILE_PX);
    localparam logic [10:0] TILE11    = 11'(TILE_PX);
    localparam logic [9:0]  STEP10    = 10'(STEP_PX);
    localparam logic [7:0]  TURN_LAST = 8'(TURN_FRAMES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic [9:0] map_x_q, map_x_d;
    logic [9:0] map_y_q, map_y_d;
    logic [9:0] step_cnt_q, step_cnt_d;
    logic [7:0] turn_cnt_q, turn_cnt_d;
    logic       vs_prev_q, vs_prev_d;
    logic       tick_q, tick_d;
    logic       req_vld;
    logic [1:0] req_dir;
    logic       in_bounds;
    logic [9:0] step_sz;
`ifdef PLAYER_RUN_EN
    logic       run_q, run_d;
    logic       walk_run_q, walk_run_d;
`endif

    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_UP;
        case (Keycode)
            8'h1A:   req_dir = DIR_UP;
            8'h07:   req_dir = DIR_RIGHT;
            8'h16:   req_dir = DIR_DOWN;
            8'h04:   req_dir = DIR_LEFT;
            default: req_vld = 1'b0;
        endcase
    end

    // Widened to 11 bits so the upper-bound test cannot overflow.
    always_comb begin
        case (dir_q)
            DIR_UP:    in_bounds = {1'b0, map_y_q} >= TILE11;
            DIR_RIGHT: in_bounds = ({1'b0, map_x_q} + TILE11) <= {1'b0, X_MAX};
            DIR_DOWN:  in_bounds = ({1'b0, map_y_q} + TILE11) <= {1'b0, Y_MAX};
            default:   in_bounds = {1'b0, map_x_q} >= TILE11;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
        step_cnt_d = step_cnt_q;
        turn_cnt_d = turn_cnt_q;
        vs_prev_d  = VS;
        tick_d     = vs_prev_q & ~VS;
        step_sz    = STEP10;
`ifdef PLAYER_RUN_EN
        // Single-keycode port: B latches run, any non-direction key drops it.
        run_d      = run_q;
        walk_run_d = walk_run_q;
        if (Keycode == 8'h05)
            run_d = 1'b1;
        else if (!req_vld)
            run_d = 1'b0;
        if (walk_run_q)
            step_sz = STEP10 << 1;
`endif
        if (tick_q) begin
            case (state_q)
                S_IDLE: begin
                    if (req_vld && req_dir != dir_q) begin
                        dir_d      = req_dir;
                        turn_cnt_d = 8'd0;
                        state_d    = S_TURN;
                    end else if (req_vld && in_bounds) begin
                        moving_d   = 1'b1;
                        step_cnt_d = 10'd0;
                        state_d    = S_WALK;
`ifdef PLAYER_RUN_EN
                        walk_run_d = run_q;
`endif
                    end
                end
                S_TURN: begin
                    turn_cnt_d = turn_cnt_q + 8'd1;
                    if (turn_cnt_q == TURN_LAST)
                        state_d = S_IDLE;
                end
                S_WALK: begin
                    case (dir_q)
                        DIR_UP:    map_y_d = map_y_q - step_sz;
                        DIR_RIGHT: map_x_d = map_x_q + step_sz;
                        DIR_DOWN:  map_y_d = map_y_q + step_sz;
                        default:   map_x_d = map_x_q - step_sz;
                    endcase
                    step_cnt_d = step_cnt_q + step_sz;
                    if (step_cnt_q + step_sz == TILE10) begin
                        moving_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            dir_q      <= DIR_DOWN;
            moving_q   <= 1'b0;
            map_x_q    <= X_INIT;
            map_y_q    <= Y_INIT;
            step_cnt_q <= 10'd0;
            turn_cnt_q <= 8'd0;
            vs_prev_q  <= 1'b1;
            tick_q     <= 1'b0;
`ifdef PLAYER_RUN_EN
            run_q      <= 1'b0;
            walk_run_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            step_cnt_q <= step_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            vs_prev_q  <= vs_prev_d;
            tick_q     <= tick_d;
`ifdef PLAYER_RUN_EN
            run_q      <= run_d;
            walk_run_q <= walk_run_d;
`endif
        end
    end

    assign Character_Moving = moving_q;
    assign Direction        = dir_q;
    assign Map_X            = map_x_q;
    assign Map_Y            = map_y_q;
    assign Frame_Tick       = tick_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// Randomized bench for player_move_ctrl against a tile/step-budget reference model.
module tb_player_move_ctrl;
    localparam int TILE_PX = 16, STEP_PX = 1, TURN_FRAMES = 4;
    localparam int X_MAX = 480, Y_MAX = 480, X_INIT = 160, Y_INIT = 160;

    logic       Clk = 1'b0;
    logic       Reset, VS;
    logic [7:0] Keycode;
    logic       Character_Moving, Frame_Tick;
    logic [1:0] Direction;
    logic [9:0] Map_X, Map_Y;

    player_move_ctrl dut (
        .Clk(Clk), .Reset(Reset), .VS(VS), .Keycode(Keycode),
        .Character_Moving(Character_Moving), .Direction(Direction),
        .Map_X(Map_X), .Map_Y(Map_Y), .Frame_Tick(Frame_Tick)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 turning, 2 walking; budgets count down.
    int DX[4] = '{0, 1, 0, -1};
    int DY[4] = '{-1, 0, 1, 0};
    int m_mode, m_dir, m_x, m_y, m_mov, m_tick, m_vsp, m_run;
    int m_turn_left, m_pix_left, m_step;

    function automatic int key2dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h07:   return 1;
            8'h16:   return 2;
            8'h04:   return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge Clk) begin
        int req, tx, ty;
        if (Reset) begin
            m_mode = 0; m_dir = 2; m_x = X_INIT; m_y = Y_INIT; m_mov = 0;
            m_tick = 0; m_vsp = 1; m_run = 0;
        end else begin
            if (m_tick != 0) begin
                case (m_mode)
                    0: begin
                        req = key2dir(Keycode);
                        if (req >= 0 && req != m_dir) begin
                            m_dir = req; m_mode = 1; m_turn_left = TURN_FRAMES;
                        end else if (req >= 0) begin
                            tx = m_x + DX[m_dir] * TILE_PX;
                            ty = m_y + DY[m_dir] * TILE_PX;
                            if (tx >= 0 && tx <= X_MAX && ty >= 0 && ty <= Y_MAX) begin
                                m_mode = 2; m_mov = 1; m_pix_left = TILE_PX;
                                m_step = (m_run != 0) ? 2 * STEP_PX : STEP_PX;
                            end
                        end
                    end
                    1: begin
                        m_turn_left--;
                        if (m_turn_left == 0) m_mode = 0;
                    end
                    default: begin
                        m_x += DX[m_dir] * m_step;
                        m_y += DY[m_dir] * m_step;
                        m_pix_left -= m_step;
                        if (m_pix_left == 0) begin m_mode = 0; m_mov = 0; end
                    end
                endcase
            end
            m_tick = (m_vsp != 0 && VS == 1'b0) ? 1 : 0;
            m_vsp  = int'(VS);
`ifdef PLAYER_RUN_EN
            if (Keycode == 8'h05) m_run = 1;
            else if (key2dir(Keycode) < 0) m_run = 0;
`endif
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("dir",   int'(Direction), m_dir);
            chk("map_x", int'(Map_X), m_x);
            chk("map_y", int'(Map_Y), m_y);
            chk("moving", int'(Character_Moving), m_mov);
            chk("tick",  int'(Frame_Tick), m_tick);
        end
    end

    // VS: random frame length with a 1-3 cycle low pulse, independent of key timing.
    int vs_cnt = 0, frame_len = 8, low_len = 2;

    task automatic hold(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            Reset   = 1'b0;
            Keycode = k;
            if (vs_cnt == 0) begin
                frame_len = $urandom_range(4, 10);
                low_len   = $urandom_range(1, 3);
            end
            VS     = (vs_cnt < low_len) ? 1'b0 : 1'b1;
            vs_cnt = (vs_cnt + 1 >= frame_len) ? 0 : vs_cnt + 1;
        end
    endtask

    logic [7:0] keys [8] = '{8'h00, 8'h1A, 8'h07, 8'h16, 8'h04, 8'h05, 8'h00, 8'h2C};

    initial begin
        Reset = 1'b1; VS = 1'b1; Keycode = 8'h00;
        @(posedge Clk); #1;
        chk_en = 1'b1;
        @(posedge Clk); #1;
        hold(8'h00, 30);
        hold(8'h04, 3000);   // walk into the left wall and bump
        hold(8'h1A, 3000);   // top wall
        hold(8'h07, 5000);   // across to the right wall
        hold(8'h16, 5000);   // down to the bottom wall
        hold(8'h00, 50);
        for (int p = 0; p < 200; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(posedge Clk); #1;
                Reset = 1'b1;
                @(posedge Clk); #1;
            end
            hold(keys[$urandom_range(0, 7)], $urandom_range(5, 200));
        end
`ifdef PLAYER_RUN_EN
        hold(8'h05, 20);
        hold(8'h16, 300);
`endif
        @(negedge Clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream neighbour of the colour mapper: turns the keyboard keycode into the player's facing Direction, a Character_Moving flag and the world scroll offset (Map_X/Map_Y) used by the background renderer.
- Movement is tile-locked in the Pokémon style: a keypress commits a full-tile step, and a direction change while idle turns the player in place first.
- All motion advances once per video frame, on a tick derived from VS.

Parameters:
- TILE_PX, 16: pixels per tile step; must be a multiple of STEP_PX.
- STEP_PX, 1: pixels moved per frame tick while walking.
- TURN_FRAMES, 4: frame ticks spent in TURN before returning to IDLE.
- X_MAX, 10'd480: largest legal Map_X; must be a multiple of TILE_PX.
- Y_MAX, 10'd480: largest legal Map_Y; must be a multiple of TILE_PX.
- X_INIT, 10'd160: Map_X reset value; tile-aligned.
- Y_INIT, 10'd160: Map_Y reset value; tile-aligned.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- VS  in  1  VGA vertical sync, active-low, synchronous to Clk
- Keycode  in  8  current USB HID keycode; 0x00 = no key
- Character_Moving  out  1  1 while a tile step is in progress
- Direction  out  2  facing: 0 up, 1 right, 2 down, 3 left
- Map_X  out  10  world X offset of the player's top-left pixel
- Map_Y  out  10  world Y offset of the player's top-left pixel
- Frame_Tick  out  1  one-Clk pulse per frame (exported for the animation FSM)

Behaviour:
- Interface: one clock, Clk; Reset is synchronous and active-high.
- Reset values:
  - Character_Moving=0, Direction=2 (down), Map_X=X_INIT, Map_Y=Y_INIT, Frame_Tick=0.
  - FSM=IDLE, step and turn counters=0, VS_prev=1.
- Frame tick:
  - VS_prev is registered each cycle.
  - Frame_Tick is registered high for one cycle when VS_prev=1 and VS=0.
  - All FSM, counter and position updates occur only on the cycle Frame_Tick=1; outputs are visible the next cycle.
- Key decode (combinational):
  - 0x1A (W) → up; 0x07 (D) → right; 0x16 (S) → down; 0x04 (A) → left.
  - Any other keycode = no direction request.
- States: IDLE, TURN, WALK.
- IDLE:
  - No request: stay.
  - Request ≠ Direction: set Direction, turn counter=0, go to TURN.
  - Request = Direction and target tile in bounds: Character_Moving=1, step counter=0, go to WALK.
  - Request = Direction and target out of bounds (Map ± TILE_PX outside [0, MAX]): stay IDLE. This is a bump: no position change, Character_Moving stays 0.
- TURN:
  - Counter increments each tick.
  - When it reaches TURN_FRAMES-1, go to IDLE.
  - Keys are ignored during TURN.
- WALK:
  - Each tick, add or subtract STEP_PX on the axis given by Direction; step counter += STEP_PX.
  - When step counter + STEP_PX == TILE_PX, that tick's move completes the tile: Character_Moving=0 and the FSM goes to IDLE.
  - Key changes and releases mid-step are ignored; the step always finishes tile-aligned.
  - A held key yields back-to-back steps with one IDLE tick between them, which the animation FSM sees as a Character_Moving low blip.
- Arithmetic:
  - 10-bit unsigned.
  - The bounds check is evaluated before entering WALK, so Map_X/Map_Y never wrap and always stay within [0, X_MAX] and [0, Y_MAX].
- Direction encoding matches the colour mapper's Direction input exactly.
- Reset asserted mid-step: all registers return to reset values on that edge. A partially stepped position is discarded.
- A Reset cycle that coincides with Frame_Tick: Reset wins.

Optional Feature:
- Macro: PLAYER_RUN_EN.
- Defined:
  - Keycode 0x05 (B) is tracked as a run modifier. Because the port carries a single keycode, a B press latches run mode and any non-direction keycode clears it.
  - When WALK is entered in run mode, the per-tick step is 2*STEP_PX for that whole tile. TILE_PX must be a multiple of 2*STEP_PX.
- Undefined: 0x05 is ignored; step is always STEP_PX; no extra logic.

Test Plan:
1. Reset, no key, 3 frames → Direction=2, Map=(160,160), Character_Moving=0, exactly one Frame_Tick per VS falling edge.
2. Keycode=0x16 held from IDLE facing down → Character_Moving=1 for 16 ticks, Map_Y=176 after the 16th tick, then 1 IDLE tick, then Map_Y=192 after the next 16 ticks.
3. Keycode=0x07 while facing down → Direction=1 next cycle, Map unchanged for 4 ticks (TURN), then walking right begins on the following tick if the key is still held.
4. Map_X=0, facing left, Keycode=0x04 → bump: Map_X stays 0, Character_Moving stays 0.
5. Start walking up, release the key at tick 5, then press A at tick 8 → step completes with Map_Y=144, Direction stays 0 throughout, Character_Moving falls after tick 16.
6. Assert Reset at tick 7 of a step → next cycle Map=(160,160), Direction=2, FSM=IDLE. With PLAYER_RUN_EN: 0x05 then 0x16 → Map_Y +16 in 8 ticks.
